sev_seg_scan: RTL

- Parametrised, time-multiplexed N-digit seven-segment display driver; successor to the single-digit BCD decoder.
- Latches a packed nibble-per-digit value and scans the digits round-robin at a programmable rate.
- Per digit it drives shared active-low segment and decimal-point lines plus an active-low digit-enable.
- Adds hex glyphs, leading-zero suppression and an anti-ghosting blank interval.
- Sits between the display register bank and the board display pins.

---
 rtl/sev_seg_pkg.sv | 42 ++++
 rtl/sev_seg_hex_decode.sv | 22 ++
 rtl/sev_seg_scan.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sev_seg_pkg.sv
// Shared types, glyph table and hex-to-segment helper for the seven-segment scan driver.
package sev_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned GLYPH_NUM = 16;
  localparam int unsigned FIRST_HEX = 10;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Active-low segments, bit 6 = segment A down to bit 0 = segment G
  localparam seg_t GLYPHS [GLYPH_NUM] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  function automatic seg_t hex_to_seg(input logic [NIBBLE_W-1:0] value,
                                      input logic                hex_en);
    seg_t result;
    result = GLYPHS[value];
    if (!hex_en && (value >= NIBBLE_W'(FIRST_HEX))) begin
      result = SEG_BLANK;
    end
    return result;
  endfunction

endpackage

// File: rtl/sev_seg_hex_decode.sv
// Combinational nibble-to-glyph decoder with a blanking override for suppressed digits.
module sev_seg_hex_decode
  import sev_seg_pkg::*;
#(
  parameter bit HEX_EN = 1'b1
) (
  input  logic [NIBBLE_W-1:0] i_value,
  input  logic                i_suppress,
  output seg_t                o_seg_c
);

  seg_t w_glyph;

  always_comb begin
    w_glyph = hex_to_seg(i_value, HEX_EN);
    o_seg_c = w_glyph;
    if (i_suppress) begin
      o_seg_c = SEG_BLANK;
    end
  end

endmodule

// File: rtl/sev_seg_scan.sv
// Time-multiplexed N-digit seven-segment driver: shadow registers, slot prescaler,
// round-robin digit index, leading-zero suppression and registered pin outputs.
module sev_seg_scan
  import sev_seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter bit          HEX_EN       = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NIBBLE_W*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]            dp_in,
  input  logic                         load,
  input  logic                         lz_en,
  output logic [6:0]                   seg,
  output logic                         dp,
  output logic [DIGITS-1:0]            an
);

  localparam int unsigned CNT_W  = $clog2(CLK_DIV);
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DATA_W = NIBBLE_W * DIGITS;

  // Elaboration-time parameter sanity
  if (DIGITS < 1) begin : g_bad_digits
    $error("sev_seg_scan: DIGITS must be >= 1");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("sev_seg_scan: CLK_DIV must be >= 2");
  end
  if (BLANK_CYCLES >= CLK_DIV) begin : g_bad_blank
    $error("sev_seg_scan: BLANK_CYCLES must be < CLK_DIV");
  end

  logic [DATA_W-1:0]   r_data;
  logic [DIGITS-1:0]   r_dp;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;

  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_slot_end;
  logic                w_blank;
  logic [NIBBLE_W-1:0] w_nibble;
  logic                w_dp_sel;
  logic                w_upper_zero_sel;
  logic [DIGITS-1:0]   w_upper_zero;
  logic                w_suppress;
  logic [DIGITS-1:0]   w_an_sel;
  seg_t                w_glyph;

  seg_t                w_seg_nxt;
  logic                w_dp_nxt;
  logic [DIGITS-1:0]   w_an_nxt;

  // Prescaler and round-robin digit index
  always_comb begin
    w_slot_end = (r_cnt == CNT_W'(CLK_DIV - 1));
    w_cnt_nxt  = r_cnt + CNT_W'(1);
    w_idx_nxt  = r_idx;
    if (w_slot_end) begin
      w_cnt_nxt = '0;
      if (r_idx == IDX_W'(DIGITS - 1)) begin
        w_idx_nxt = '0;
      end else begin
        w_idx_nxt = r_idx + IDX_W'(1);
      end
    end
  end

  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign w_blank = 1'b0;
  end else begin : g_blank
    assign w_blank = (r_cnt < CNT_W'(BLANK_CYCLES));
  end

  // Leading-zero chain: bit i set when digits i..DIGITS-1 are all zero
  always_comb begin
    w_upper_zero             = '0;
    w_upper_zero[DIGITS-1]   = (r_data[DATA_W-1 -: NIBBLE_W] == '0);
    for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
      w_upper_zero[i] = w_upper_zero[i+1] & (r_data[NIBBLE_W*i +: NIBBLE_W] == '0);
    end
  end

  // Select the active digit's nibble, dp and zero flag; build the one-cold enable
  always_comb begin
    w_nibble         = '0;
    w_dp_sel         = 1'b0;
    w_upper_zero_sel = 1'b0;
    w_an_sel         = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nibble         = r_data[NIBBLE_W*i +: NIBBLE_W];
        w_dp_sel         = r_dp[i];
        w_upper_zero_sel = w_upper_zero[i];
        w_an_sel[i]      = 1'b0;
      end
    end
  end

  // Digit 0 always shows its value, even when everything above it is zero
  assign w_suppress = lz_en & (r_idx != '0) & w_upper_zero_sel;

  sev_seg_hex_decode #(
    .HEX_EN (HEX_EN)
  ) u_decode (
    .i_value    (w_nibble),
    .i_suppress (w_suppress),
    .o_seg_c    (w_glyph)
  );

  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_dp_nxt  = 1'b1;
    w_an_nxt  = '1;
    if (!w_blank) begin
      w_seg_nxt = w_glyph;
      w_dp_nxt  = ~w_dp_sel;
      w_an_nxt  = w_an_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_dp   <= '0;
      r_cnt  <= '0;
      r_idx  <= '0;
      seg    <= SEG_BLANK;
      dp     <= 1'b1;
      an     <= '1;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
      if (load) begin
        r_data <= data;
        r_dp   <= dp_in;
      end
      seg <= w_seg_nxt;
      dp  <= w_dp_nxt;
      an  <= w_an_nxt;
    end
  end

endmodule
